// File: rtl/spim_burst_if.sv
// CPU-side register bus of the burst SPI master (I/O decoder <-> spim_burst).
`timescale 1ns/1ps
interface spim_burst_if;
  // Handshake: the CPU raises reg_xfer_we (with reg_di/reg_len stable) and holds
  // it; the core answers with reg_wait high until the single cycle in which the
  // burst is done, when reg_do is valid and the CPU may drop reg_xfer_we. A new
  // burst needs reg_xfer_we to go low and high again. reg_ctrl_we is a
  // one-cycle strobe, accepted only while the core is idle.
  logic        reg_xfer_we;
  logic [1:0]  reg_len;
  logic        reg_ctrl_we;
  logic [31:0] reg_di;
  logic [31:0] reg_do;
  logic        reg_wait;
  logic        busy;

  modport master (
    output reg_xfer_we, reg_len, reg_ctrl_we, reg_di,
    input  reg_do, reg_wait, busy
  );

  modport slave (
    input  reg_xfer_we, reg_len, reg_ctrl_we, reg_di,
    output reg_do, reg_wait, busy
  );
endinterface

// File: rtl/spim_burst.sv
// Burst SPI master: 1..MAX_BYTES bytes per CPU access, programmable SCK divider,
// software chip selects. Define SPIM_MODE_EN to honour CPOL/CPHA; otherwise mode 0.
`timescale 1ns/1ps
module spim_burst #(
  parameter int MAX_BYTES = 4,
  parameter int DIV_RESET = 2,
  parameter int NUM_CS    = 1
) (
  input  logic              clk,
  input  logic              resetn,
  spim_burst_if.slave       bus,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] LEN_MAX  = 2'(MAX_BYTES - 1);
  localparam logic [7:0] DIV_INIT = 8'(DIV_RESET);

  state_t            state, state_nx;
  logic              xfer_armed, xfer_req, ctrl_wr;
  logic [7:0]        div_q, div_eff, div_cnt;
  logic [NUM_CS-1:0] cs_q;
  logic              cpol, cpha;
  logic [3:0]        phase;
  logic              phase_end, last_phase, lead, trail, shift_ev, sample_ev;
  logic [1:0]        len_q, len_eff, byte_k, byte_k_nx;
  logic [31:0]       tx_data, rx_word;
  logic [7:0]        tx_sr, rx_sr, nx_byte;

  // The arm flag records "request was low last cycle" and resets to 0, so a
  // level still high when reset releases never starts a burst.
  assign xfer_req  = bus.reg_xfer_we & xfer_armed;
  assign ctrl_wr   = bus.reg_ctrl_we & (state == S_IDLE);
  assign len_eff   = (bus.reg_len > LEN_MAX) ? LEN_MAX : bus.reg_len;
  assign div_eff   = (div_q == 8'd0) ? 8'd1 : div_q;

  assign phase_end  = (state == S_SHIFT) && (div_cnt == div_eff - 8'd1);
  assign last_phase = (phase == 4'd15);
  assign lead       = phase_end & ~phase[0];
  assign trail      = phase_end & phase[0];
  // CPHA=0 presents bit 7 at load and shifts on trailing edges; CPHA=1 shifts on leading edges.
  assign shift_ev   = cpha ? lead : (trail & ~last_phase);
  assign sample_ev  = cpha ? trail : lead;

  assign byte_k_nx  = byte_k + 2'd1;
  assign nx_byte    = tx_data[{byte_k_nx, 3'b000} +: 8];

`ifdef SPIM_MODE_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cpol <= 1'b0;
      cpha <= 1'b0;
    end else if (ctrl_wr) begin
      cpol <= bus.reg_di[8];
      cpha <= bus.reg_di[9];
    end
  end
`else
  assign cpol = 1'b0;
  assign cpha = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (xfer_req) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_SHIFT;
      S_SHIFT: if (phase_end && last_phase) state_nx = S_NEXT;
      S_NEXT:  state_nx = (byte_k < len_q) ? S_SHIFT : S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = (state != S_IDLE);
    bus.reg_wait = bus.reg_xfer_we & (state != S_DONE);
    sck          = cpol ^ ((state == S_SHIFT) & phase[0]);
    dbg_state    = state;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      xfer_armed <= 1'b0;
      div_q      <= DIV_INIT;
      cs_q       <= '1;
      tx_data    <= '0;
      rx_word    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      mosi       <= 1'b1;
      phase      <= '0;
      div_cnt    <= '0;
      len_q      <= '0;
      byte_k     <= '0;
    end else begin
      xfer_armed <= ~bus.reg_xfer_we;
      if (ctrl_wr) begin
        div_q <= bus.reg_di[7:0];
        cs_q  <= bus.reg_di[16 +: NUM_CS];
      end
      if (sample_ev) rx_sr <= {rx_sr[6:0], miso};
      if (shift_ev) begin
        mosi  <= tx_sr[7];
        tx_sr <= {tx_sr[6:0], 1'b0};
      end
      if (state == S_SHIFT) begin
        if (phase_end) begin
          div_cnt <= '0;
          phase   <= phase + 4'd1;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
      end
      if (state == S_LOAD) begin
        tx_data <= bus.reg_di;
        len_q   <= len_eff;
        byte_k  <= '0;
        rx_word <= '0;
        phase   <= '0;
        div_cnt <= '0;
        if (cpha) begin
          tx_sr <= bus.reg_di[7:0];
        end else begin
          mosi  <= bus.reg_di[7];
          tx_sr <= {bus.reg_di[6:0], 1'b0};
        end
      end
      if (state == S_NEXT) begin
        rx_word[{byte_k, 3'b000} +: 8] <= rx_sr;
        if (byte_k < len_q) begin
          byte_k  <= byte_k_nx;
          phase   <= '0;
          div_cnt <= '0;
          if (cpha) begin
            tx_sr <= nx_byte;
          end else begin
            mosi  <= nx_byte[7];
            tx_sr <= {nx_byte[6:0], 1'b0};
          end
        end
      end
    end
  end

  assign cs_n       = cs_q;
  assign bus.reg_do = rx_word;

endmodule

// File: doc/spim_burst.md
# spim_burst

Parametrised SPI master for the picorv32 I/O system, successor to the fixed 1-/4-byte SD-card SPI port. It transfers 1..MAX_BYTES bytes per CPU access, stalling the bus via `reg_wait` until the burst completes. It adds a programmable SCK divider, software-driven chip selects for NUM_CS devices, and optional CPOL/CPHA modes. It sits behind the I/O address decoder next to the UART and drives the SD card and any additional SPI peripherals.

## Interface

Parameters:
- MAX_BYTES, 4, max bytes per burst (1..4); data path 8*MAX_BYTES bits inside 32-bit regs
- DIV_RESET, 2, reset value of half-bit divider (clk cycles per SCK half period)
- NUM_CS, 1, number of chip-select outputs (1..8)

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low; clock clk
- sck  out  1  SPI clock
- mosi  out  1  SPI data out
- miso  in  1  SPI data in
- cs_n  out  NUM_CS  chip selects, active-low, software-controlled
- reg_xfer_we  in  1  level; rising edge starts a burst, held until `reg_wait` falls
- reg_len  in  2  burst length minus 1; values ≥ MAX_BYTES clamp to MAX_BYTES-1
- reg_ctrl_we  in  1  one-cycle write of control register from `reg_di`
- reg_di  in  32  TX data / control data
- reg_do  out  32  RX data of last burst
- reg_wait  out  1  bus stall
- busy  out  1  burst in progress

## Operation

- Control register fields: [7:0] div (0 treated as 1); [8] CPOL; [9] CPHA; [23:16] cs_n value. Only bits [16+NUM_CS-1:16] are used.
- reg_ctrl_we while busy: ignored.
- reg_ctrl_we coincident with a request edge: control is applied first, and the burst uses the new settings.
- FSM states:
  - IDLE → LOAD on rising edge of reg_xfer_we (edge detector registered; reset value 0).
  - LOAD: latch reg_di and clamped reg_len, load byte 0, clear reg_do → SHIFT.
  - SHIFT: 16 half-bit phases, each div cycles → NEXT.
  - NEXT: store rx byte k into reg_do[8k+:8]. If k < len, load byte k+1 → SHIFT; else → DONE.
  - DONE: drop reg_wait one cycle → IDLE.
- Byte k = reg_di[8k+:8], sent in order k = 0 first, MSB first within each byte. reg_do bytes above len read 0.
- reg_wait = reg_xfer_we & ~done. It stays high on the first cycle of a request (combinational).
- A new burst requires reg_xfer_we to go low and then high again. A level held high after DONE never retriggers.
- busy is high from LOAD through DONE inclusive.
- cs_n is never toggled by hardware during a burst.

## Timing

- Reset values:
  - sck = 0, mosi = 1, cs_n = all 1, reg_do = 0, reg_wait = reg_xfer_we, busy = 0.
  - div = DIV_RESET, CPOL = CPHA = 0, FSM = IDLE.
- Reset mid-burst aborts immediately; outputs take reset values on the next edge.
- Request edge sampled at cycle 0; LOAD at cycle 1. First bit on mosi from cycle 2 (CPHA=0).
- Each byte takes 16*div cycles of SHIFT plus 1 NEXT cycle.
- n-byte burst: done (reg_wait low) at cycle 2 + n*(16*div+1). reg_do is valid in that cycle and held until the next LOAD.
- sck idles at CPOL between bytes and after the burst.
- CPHA=0: mosi changes on the trailing edge; miso is sampled on the leading edge.
- CPHA=1: mosi changes on the leading edge; miso is sampled on the trailing edge.

## Configuration

- SPIM_MODE_EN defined: CPOL/CPHA bits are honoured as above.
- SPIM_MODE_EN undefined: bits [9:8] are ignored and forced to 0; the core always runs mode 0. The FSM, divider and latency are otherwise identical.

## Test plan

- Reset, then 1-byte burst, div=2, reg_di=0xA5, miso looped to mosi → reg_do=0x000000A5; reg_wait falls at cycle 35; 8 sck pulses.
- 4-byte burst, reg_di=0x12345678, miso fixed 1, div=1 → mosi sends 78,56,34,12; reg_do=0xFFFFFFFF; done at cycle 70.
- reg_len=3 with MAX_BYTES=2 → exactly 2 bytes sent; reg_do[31:16]=0.
- Control write cs_n=0xFE, div=0 → cs_n[0]=0; burst runs at div=1. Control write during a burst → cs_n unchanged.
- SPIM_MODE_EN, CPOL=1, CPHA=1, byte 0x3C → sck idles 1; mosi bits change on falling edges; loopback reg_do=0x3C.
- resetn low mid-burst, then reg_xfer_we held high → no new burst until the level toggles; outputs at reset values.
